// File: rtl/pla_bist_sweep_if.sv
// Bundle of control, status and PLA-facing signals for the PLA BIST sweep engine.
// The slave view belongs to the sweep engine; the master view belongs to the
// test controller plus the PLA under test.
interface pla_bist_sweep_if #(
    parameter int N_IN  = 14,
    parameter int N_OUT = 14
);
    logic             start;
    logic             abort;
    logic             hold;
    logic [N_OUT-1:0] golden;
    logic [N_IN-1:0]  pla_in;
    logic [N_OUT-1:0] pla_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_OUT-1:0] signature;

    modport slave (
        input  start,
        input  abort,
        input  hold,
        input  golden,
        input  pla_out,
        output pla_in,
        output busy,
        output done,
        output pass,
        output signature
    );

    modport master (
        output start,
        output abort,
        output hold,
        output golden,
        output pla_out,
        input  pla_in,
        input  busy,
        input  done,
        input  pass,
        input  signature
    );
endinterface

// File: rtl/pla_bist_sweep.sv
// Exhaustive BIST sweep for a combinational PLA: counts through every input
// vector, folds each response into a Galois MISR and compares the final
// signature with a golden value.
module pla_bist_sweep #(
    parameter int               N_IN  = 14,
    parameter int               N_OUT = 14,
    parameter logic [N_OUT-1:0] POLY  = 14'h002B,
    parameter logic [N_OUT-1:0] SEED  = '0
) (
    input logic              clk,
    input logic              rst,
    pla_bist_sweep_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  pla_in_q, pla_in_d;
    logic [N_OUT-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic [N_OUT-1:0] misr_next;

    // Next-state logic: start (re)loads the sweep, RUN advances unless frozen or aborted
    always_comb begin
        state_d  = state_q;
        pla_in_d = pla_in_q;
        sig_d    = sig_q;
        pass_d   = pass_q;

        misr_next = {sig_q[N_OUT-2:0], 1'b0}
                  ^ (sig_q[N_OUT-1] ? POLY : '0)
                  ^ bus.pla_out;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    pla_in_d = '0;
                    sig_d    = SEED;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    pla_in_d = '0;
                end else if (!bus.hold) begin
                    sig_d    = misr_next;
                    pla_in_d = pla_in_q + 1'b1;
                    if (pla_in_q == LAST_VEC) begin
                        state_d = DONE;
                        pass_d  = (misr_next == bus.golden);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                pla_in_d = '0;
                sig_d    = SEED;
                pass_d   = 1'b0;
            end
        endcase
    end

    // State, vector counter, MISR and verdict registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pla_in_q <= '0;
            sig_q    <= SEED;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pla_in_q <= pla_in_d;
            sig_q    <= sig_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.pla_in    = pla_in_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_pla_bist_sweep.sv
// Directed self-checking bench for pla_bist_sweep with a small 3-in/4-out PLA
// model (pla_out = {1'b0, pla_in}) and a scoreboard of expected vectors and signatures.
module tb_pla_bist_sweep;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    int         exp_vec_q[$];
    logic [3:0] exp_sig_q[$];
    logic [3:0] exp_final_q[$];
    logic       exp_pass_q[$];
    logic [3:0] model_sig;

    pla_bist_sweep_if #(.N_IN(3), .N_OUT(4)) bus ();

    pla_bist_sweep #(
        .N_IN  (3),
        .N_OUT (4),
        .POLY  (4'h3),
        .SEED  (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PLA under test: purely combinational response to the applied vector
    assign bus.pla_out = {1'b0, bus.pla_in};

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] misrModel(input logic [3:0] s, input logic [3:0] d);
        logic [3:0] fb;
        fb = s[3] ? 4'h3 : 4'h0;
        return {s[2:0], 1'b0} ^ fb ^ d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic h);
        bus.start = s;
        bus.abort = a;
        bus.hold  = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        model_sig = 4'h0;
    endtask

    // Push the expected vector/signature schedule, then step the DUT through it
    task automatic runVectors(input int n_vec, input int hold_at, input int hold_n, input logic keep_start);
        logic [3:0] s;
        int         reps;
        int         ev;
        logic [3:0] es;
        s = model_sig;
        for (int v = 0; v < n_vec; v++) begin
            reps = (v == hold_at) ? hold_n : 0;
            for (int r = 0; r <= reps; r++) begin
                exp_vec_q.push_back(v);
                exp_sig_q.push_back(s);
            end
            s = misrModel(s, v[3:0]);
        end
        for (int v = 0; v < n_vec; v++) begin
            reps = (v == hold_at) ? hold_n : 0;
            for (int r = 0; r <= reps; r++) begin
                ev = exp_vec_q.pop_front();
                es = exp_sig_q.pop_front();
                checkOutput("run_pla_in", 32'(bus.pla_in), 32'(ev));
                checkOutput("run_busy", 32'(bus.busy), 32'd1);
                checkOutput("run_done", 32'(bus.done), 32'd0);
                checkOutput("run_signature", 32'(bus.signature), 32'(es));
                applyStimulus(keep_start, 1'b0, (v == hold_at) && (r < reps));
                tick();
            end
        end
        applyStimulus(keep_start, 1'b0, 1'b0);
        model_sig = s;
    endtask

    task automatic checkDone();
        logic [3:0] ef;
        logic       ep;
        ef = exp_final_q.pop_front();
        ep = exp_pass_q.pop_front();
        checkOutput("done_done", 32'(bus.done), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd0);
        checkOutput("done_pla_in", 32'(bus.pla_in), 32'd0);
        checkOutput("done_signature", 32'(bus.signature), 32'(ef));
        checkOutput("done_pass", 32'(bus.pass), 32'(ep));
    endtask

    task automatic checkIdle(input string tag, input logic [3:0] sig);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_pla_in"}, 32'(bus.pla_in), 32'd0);
        checkOutput({tag, "_signature"}, 32'(bus.signature), 32'(sig));
    endtask

    // Linear sequence of directed scenarios
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.golden = 4'hF;
        model_sig  = 4'h0;

        #12;
        checkIdle("reset", 4'h0);
        checkOutput("reset_pass", 32'(bus.pass), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] plain sweep, golden=F");
        bus.golden = 4'hF;
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        pulseStart();
        runVectors(8, -1, 0, 1'b0);
        checkDone();
        tick();
        checkOutput("done_hold_done", 32'(bus.done), 32'd1);
        checkOutput("done_hold_signature", 32'(bus.signature), 32'hF);
        checkOutput("done_hold_pass", 32'(bus.pass), 32'd1);

        $display("[TB] sweep with wrong golden=E");
        bus.golden = 4'hE;
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b0);
        pulseStart();
        checkOutput("restart_pass_cleared", 32'(bus.pass), 32'd0);
        runVectors(8, -1, 0, 1'b0);
        checkDone();

        $display("[TB] sweep with 3 hold cycles at vector 4");
        bus.golden = 4'hF;
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        pulseStart();
        runVectors(8, 4, 3, 1'b0);
        checkDone();

        $display("[TB] abort at vector 5");
        pulseStart();
        runVectors(5, -1, 0, 1'b0);
        checkOutput("abort_pre_pla_in", 32'(bus.pla_in), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle("abort", 4'h2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle("abort_idle", 4'h2);
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        pulseStart();
        runVectors(8, -1, 0, 1'b0);
        checkDone();

        $display("[TB] start held high through the sweep");
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        model_sig = 4'h0;
        runVectors(8, -1, 0, 1'b1);
        checkDone();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resweep_done", 32'(bus.done), 32'd0);
        checkOutput("resweep_pass", 32'(bus.pass), 32'd0);
        model_sig = 4'h0;
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        runVectors(8, -1, 0, 1'b0);
        checkDone();

        $display("[TB] asynchronous reset at vector 3");
        pulseStart();
        runVectors(3, -1, 0, 1'b0);
        checkOutput("rst_pre_pla_in", 32'(bus.pla_in), 32'd3);
        rst = 1'b1;
        #2;
        checkIdle("async_rst", 4'h0);
        checkOutput("async_rst_pass", 32'(bus.pass), 32'd0);
        #4;
        rst = 1'b0;
        tick();
        checkIdle("post_rst", 4'h0);
        exp_final_q.push_back(4'hF);
        exp_pass_q.push_back(1'b1);
        pulseStart();
        runVectors(8, -1, 0, 1'b0);
        checkDone();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
